booth_mult_seq: RTL
===================

Name: booth_mult_seq

Overview:
- Sequential radix-2 Booth signed multiplier for the multdiv unit: 32x32 signed operands, 32-bit truncated product, overflow exception.
- Each iteration adds, subtracts or skips the multiplicand into the upper half of a 65-bit product register, then arithmetic-shifts right by 1.
- One iteration per cycle, through a single instance of the team's 32-bit CLA adder.
- Output feeds the processor's multdiv result mux and stall logic.

Parameters:
- WIDTH, 32: operand and result width. Only 32 is supported; the adder is fixed at 32 bits.
- CNT_W, 5: iteration counter width, log2(WIDTH).

Ports:
- clock  input  1  rising-edge clock
- reset_n  input  1  asynchronous active-low reset
- ctrl_mult  input  1  start pulse; operands sampled on the same edge
- data_operandA  input  32  multiplicand M, signed
- data_operandB  input  32  multiplier Q, signed
- data_result  output  32  low 32 bits of the signed product
- data_exception  output  1  product not representable in 32-bit signed
- data_resultRDY  output  1  one-cycle done pulse
- busy  output  1  high while iterating

Behaviour:
- Reset (async, reset_n=0):
  - state=IDLE; all registers 0.
  - data_result=0, data_exception=0, data_resultRDY=0, busy=0.
  - Release is synchronous to clock; first start is honoured on the first edge after release.
- States: IDLE, RUN, DONE.
- Start:
  - ctrl_mult=1 at edge E0, in any state including RUN and DONE:
    - latch M=data_operandA
    - P_hi=0, P_lo=data_operandB, q_m1=0
    - count=0, state=RUN
  - Restart mid-RUN abandons the current operation; no RDY is produced for it.
- RUN, each edge:
  - {P_lo[0], q_m1}=01: adder computes P_hi + M (Cin=0).
  - {P_lo[0], q_m1}=10: adder computes P_hi + ~M with Cin=1, i.e. P_hi - M.
  - {P_lo[0], q_m1}=00 or 11: adder computes P_hi + 0.
  - True sign of the sum: sgn = s[31] XOR adder overflow. This is required; it makes M=0x80000000 subtract correctly.
  - Shift: {P_hi, P_lo, q_m1} <= {sgn, s[31:0], P_lo[31:0]}, dropping the old q_m1.
  - count increments. The edge with count=31 performs the final iteration and moves to DONE.
- Latency: 32 iterations on E1..E32. data_resultRDY=1 for exactly one cycle, between E32 and E33.
- DONE:
  - data_resultRDY=1; next edge returns to IDLE unless ctrl_mult restarts.
  - If ctrl_mult=1 during DONE, RDY still shows in that cycle and the new operation begins.
- Outputs:
  - data_result = P_lo.
  - data_exception = (P_hi != {32{P_lo[31]}}), registered at E32.
  - Both hold their values after DONE until the next start, then clear to 0.
- busy=1 exactly in RUN.
- ctrl_mult=0 in IDLE: no state change.
- Operand inputs are ignored except on the start edge.

Decomposition:
- Shared multdiv package holds:
  - state encoding (IDLE=2'd0, RUN=2'd1, DONE=2'd2)
  - WIDTH and CNT_W constants
  - Booth decode constants (ADD, SUB, NOP)
- One sub-module: the existing 32-bit CLA adder, reused unchanged.
  - Operand B is a mux of {0, M, ~M}.
  - Carry-in is the SUB decode bit.
  - Its overflow output is used only for sign correction.
- Everything else stays in one file: FSM, counter and product register.

Test Plan:
- 3 x 5: start at E0 -> RDY only in the cycle after E32; data_result=0x0000000F; data_exception=0; busy high E1..E32.
- -7 x 6 (0xFFFFFFF9, 0x00000006) -> data_result=0xFFFFFFD6; exception=0. Also 0x80000000 x 0x00000001 -> 0x80000000, exception=0.
- 0x00010000 x 0x00010000 -> result=0x00000000, exception=1. Also 0x80000000 x 0xFFFFFFFF -> result=0x80000000, exception=1 (checks subtract-of-most-negative sign correction).
- Restart mid-RUN: start 3 x 5, reissue ctrl_mult with 2 x 9 at E10 -> single RDY 32 cycles after E10; result=0x00000012; no RDY near E32 of the first operation.
- reset_n=0 asynchronously mid-RUN (E15) -> all outputs 0 immediately, no RDY. After release, a new start with 7 x 7 -> 0x00000031.
- Random signed pairs (1000) against a 64-bit reference model: result=low 32 bits; exception equals the 64-bit product out of 32-bit signed range.

Source files
------------

// File: rtl/booth_mult_seq_pkg.sv
// Shared multdiv definitions: FSM state encoding, datapath sizes and Booth decode.
package booth_mult_seq_pkg;

  localparam int unsigned MD_WIDTH = 32;
  localparam int unsigned MD_CNT_W = 5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [1:0] BOOTH_NOP = 2'b00;
  localparam logic [1:0] BOOTH_ADD = 2'b01;
  localparam logic [1:0] BOOTH_SUB = 2'b10;

  // {q0, q_-1} pair -> adder operation; 00 and 11 both skip.
  function automatic logic [1:0] booth_decode(input logic q0, input logic qm1);
    case ({q0, qm1})
      2'b01:   booth_decode = BOOTH_ADD;
      2'b10:   booth_decode = BOOTH_SUB;
      default: booth_decode = BOOTH_NOP;
    endcase
  endfunction

endpackage

// File: rtl/booth_mult_seq_cla.sv
// 32-bit carry-lookahead adder: 4-bit lookahead groups chained at group boundaries.
module booth_mult_seq_cla (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        cin,
  output logic [31:0] s,
  output logic        cout,
  output logic        ovf
);

  logic [31:0] g;
  logic [31:0] p;
  logic [32:0] c;

  assign g = a & b;
  assign p = a ^ b;

  always_comb begin
    logic gg;
    logic pp;
    c    = '0;
    c[0] = cin;
    for (int unsigned k = 0; k < 8; k++) begin
      gg = 1'b0;
      pp = 1'b1;
      for (int unsigned j = 0; j < 4; j++) begin
        gg = g[4*k+j] | (p[4*k+j] & gg);
        pp = pp & p[4*k+j];
        c[4*k+j+1] = gg | (pp & c[4*k]);
      end
    end
  end

  assign s    = p ^ c[31:0];
  assign cout = c[32];
  assign ovf  = c[32] ^ c[31];

endmodule

// File: rtl/booth_mult_seq.sv
// Sequential radix-2 Booth signed multiplier, one iteration per cycle through a shared CLA.
module booth_mult_seq
  import booth_mult_seq_pkg::*;
#(
  parameter int WIDTH = MD_WIDTH,
  parameter int CNT_W = MD_CNT_W
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             ctrl_mult,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  output logic [WIDTH-1:0] data_result,
  output logic             data_exception,
  output logic             data_resultRDY,
  output logic             busy
);

  state_t             state;
  logic [WIDTH-1:0]   m;
  logic [WIDTH-1:0]   p_hi;
  logic [WIDTH-1:0]   p_lo;
  logic               q_m1;
  logic [CNT_W-1:0]   count;
  logic [WIDTH-1:0]   res_q;
  logic               exc_q;
  logic               rdy_q;
  logic               busy_q;

  logic [1:0]         booth_op;
  logic [WIDTH-1:0]   add_b;
  logic               add_cin;
  logic [WIDTH-1:0]   sum;
  logic               add_cout;
  logic               add_ovf;
  logic               sgn;
  logic [WIDTH-1:0]   p_hi_nx;
  logic [WIDTH-1:0]   p_lo_nx;

  always_comb begin
    booth_op = booth_decode(p_lo[0], q_m1);
    add_b    = '0;
    case (booth_op)
      BOOTH_ADD: add_b = m;
      BOOTH_SUB: add_b = ~m;
      default:   add_b = '0;
    endcase
    add_cin = (booth_op == BOOTH_SUB);
  end

  booth_mult_seq_cla u_cla (
    .a    (p_hi),
    .b    (add_b),
    .cin  (add_cin),
    .s    (sum),
    .cout (add_cout),
    .ovf  (add_ovf)
  );

  // The 32-bit sum can wrap; the true sign restores the 33rd bit before the arithmetic shift.
  assign sgn     = sum[WIDTH-1] ^ add_ovf;
  assign p_hi_nx = {sgn, sum[WIDTH-1:1]};
  assign p_lo_nx = {sum[0], p_lo[WIDTH-1:1]};

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state  <= IDLE;
      m      <= '0;
      p_hi   <= '0;
      p_lo   <= '0;
      q_m1   <= 1'b0;
      count  <= '0;
      res_q  <= '0;
      exc_q  <= 1'b0;
      rdy_q  <= 1'b0;
      busy_q <= 1'b0;
    end else begin
      rdy_q <= 1'b0;
      if (ctrl_mult) begin
        m      <= data_operandA;
        p_hi   <= '0;
        p_lo   <= data_operandB;
        q_m1   <= 1'b0;
        count  <= '0;
        res_q  <= '0;
        exc_q  <= 1'b0;
        busy_q <= 1'b1;
        state  <= RUN;
      end else begin
        case (state)
          RUN: begin
            p_hi  <= p_hi_nx;
            p_lo  <= p_lo_nx;
            q_m1  <= p_lo[0];
            count <= count + 1'b1;
            if (count == '1) begin
              res_q  <= p_lo_nx;
              exc_q  <= (p_hi_nx != {WIDTH{p_lo_nx[WIDTH-1]}});
              rdy_q  <= 1'b1;
              busy_q <= 1'b0;
              state  <= DONE;
            end
          end
          DONE:    state <= IDLE;
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign data_result    = res_q;
  assign data_exception = exc_q;
  assign data_resultRDY = rdy_q;
  assign busy           = busy_q;

endmodule
